// File: rtl/button_debounce.sv
// Four-button debouncer with single-press arbitration and lockout on multi-press.
// Optional auto-repeat while a press is held: define BUTTON_AUTOREPEAT_EN.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    output logic [3:0] button,
    output logic       press
);
    localparam int            DW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]    RELEASED = 4'b1111;

    typedef enum logic [1:0] {IDLE, PRESSED, LOCKOUT} state_t;

    logic [3:0]    s1, s2, stable;
    logic [DW-1:0] db_cnt [4];
    state_t        state;
    logic [3:0]    pattern;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int            RW        = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] rep_cnt;
    logic          repeating;
`else
    // Hold and repeat timing only matter when auto-repeat is built.
    logic unused_cfg;
    assign unused_cfg = (HOLD_CYCLES > 0) && (REPEAT_CYCLES > 0);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= RELEASED;
            s2 <= RELEASED;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // NOTE: db_cnt is a small flop array, not a RAM, so it is cleared with the rest of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            stable <= RELEASED;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] >= DB_LAST) begin
                    stable[i] <= s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            pattern <= RELEASED;
            button  <= RELEASED;
            press   <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
            hold_cnt  <= '0;
            rep_cnt   <= '0;
            repeating <= 1'b0;
`endif
        end else begin
            // NOTE: press defaults low every cycle; a later non-blocking write in this block wins.
            press <= 1'b0;
            case (state)
                IDLE: begin
                    button <= RELEASED;
                    if ($countones(~stable) == 1) begin
                        state   <= PRESSED;
                        pattern <= stable;
                        button  <= stable;
                        press   <= 1'b1;
                    end else if (stable != RELEASED) begin
                        state <= LOCKOUT;
                    end
                end
                PRESSED: begin
                    if (stable != pattern) begin
                        state  <= (stable == RELEASED) ? IDLE : LOCKOUT;
                        button <= RELEASED;
                    end
`ifdef BUTTON_AUTOREPEAT_EN
                    else if (!repeating) begin
                        if (hold_cnt >= HOLD_LAST) begin
                            repeating <= 1'b1;
                            rep_cnt   <= '0;
                            button    <= RELEASED;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end else if (button == RELEASED) begin
                        // End of the one-cycle release gap: re-issue the press.
                        button  <= pattern;
                        press   <= 1'b1;
                        rep_cnt <= rep_cnt + 1'b1;
                    end else if (rep_cnt >= REP_LAST) begin
                        button  <= RELEASED;
                        rep_cnt <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
`endif
                end
                LOCKOUT: begin
                    button <= RELEASED;
                    if (stable == RELEASED) state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    button <= RELEASED;
                end
            endcase
`ifdef BUTTON_AUTOREPEAT_EN
            // Hold timing restarts on every entry to PRESSED.
            if (state != PRESSED || stable != pattern) begin
                hold_cnt  <= '0;
                rep_cnt   <= '0;
                repeating <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed vector table, multi-cycle sequences and random
// stimulus compared every cycle against a behavioural model.
module tb_button_debounce;
    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;
`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] button;
    logic       press;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    button_debounce #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .btn_raw(btn_raw),
        .button (button),
        .press  (press)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Behavioural model: a level is accepted once the twice-delayed sample has
    // disagreed with the accepted level for DB consecutive edges.
    typedef enum logic [1:0] {M_IDLE, M_PRESSED, M_LOCKOUT} mode_t;
    typedef struct packed {
        logic [3:0]        stable;
        logic [DB:0][3:0]  sh;
        mode_t             mode;
        logic [3:0]        pat;
        int                k;
        logic [3:0]        button;
        logic              press;
    } model_t;

    function automatic bit rep_gap(input int k);
        return AUTOREP && k >= HOLD && ((k - HOLD) % REP) == 0;
    endfunction

    function automatic bit rep_press(input int k);
        return AUTOREP && k > HOLD && ((k - HOLD - 1) % REP) == 0;
    endfunction

    function automatic model_t model_next(input model_t m, input logic [3:0] raw, input logic rst);
        model_t n;
        bit     all_diff;
        n = m;
        if (rst) begin
            n.stable = 4'hF;
            n.sh     = '1;
            n.mode   = M_IDLE;
            n.pat    = 4'hF;
            n.k      = 0;
            n.button = 4'hF;
            n.press  = 1'b0;
            return n;
        end
        n.press = 1'b0;
        case (m.mode)
            M_IDLE: begin
                n.button = 4'hF;
                if ($countones(~m.stable) == 1) begin
                    n.mode   = M_PRESSED;
                    n.pat    = m.stable;
                    n.k      = 0;
                    n.button = m.stable;
                    n.press  = 1'b1;
                end else if (m.stable != 4'hF) begin
                    n.mode = M_LOCKOUT;
                end
            end
            M_PRESSED: begin
                if (m.stable != m.pat) begin
                    n.mode   = (m.stable == 4'hF) ? M_IDLE : M_LOCKOUT;
                    n.button = 4'hF;
                end else begin
                    n.k      = m.k + 1;
                    n.button = rep_gap(n.k) ? 4'hF : m.pat;
                    n.press  = rep_press(n.k);
                end
            end
            default: begin
                n.button = 4'hF;
                if (m.stable == 4'hF) n.mode = M_IDLE;
            end
        endcase
        for (int b = 0; b < 4; b++) begin
            all_diff = 1'b1;
            for (int i = 1; i <= DB; i++)
                if (m.sh[i][b] == m.stable[b]) all_diff = 1'b0;
            if (all_diff) n.stable[b] = ~m.stable[b];
        end
        n.sh = {m.sh[DB-1:0], raw};
        return n;
    endfunction

    model_t m;
    always @(posedge clock) m <= model_next(m, btn_raw, reset);

    always @(negedge clock) begin
        if (chk_en) begin
            check("model button", button, m.button);
            check("model press", {3'b000, press}, {3'b000, m.press});
        end
    end

    typedef struct {
        logic [3:0] raw;
        int         cycles;
        logic [3:0] exp_button;
        logic       exp_press;
    } vec_t;

    vec_t       tbl [14];
    logic [3:0] exp_b;
    logic       exp_p;
    int         r_sel;
    int         r_len;

    initial begin
        reset   = 1'b1;
        btn_raw = 4'hF;

        tbl[0]  = '{4'b0111, 6,  4'b1111, 1'b0};
        tbl[1]  = '{4'b0111, 1,  4'b0111, 1'b1};
        tbl[2]  = '{4'b0111, 1,  4'b0111, 1'b0};
        tbl[3]  = '{4'b1111, 7,  4'b1111, 1'b0};
        tbl[4]  = '{4'b1011, 7,  4'b1011, 1'b1};
        tbl[5]  = '{4'b0011, 7,  4'b1111, 1'b0};
        tbl[6]  = '{4'b1011, 10, 4'b1111, 1'b0};
        tbl[7]  = '{4'b1111, 7,  4'b1111, 1'b0};
        tbl[8]  = '{4'b1101, 7,  4'b1101, 1'b1};
        tbl[9]  = '{4'b1111, 8,  4'b1111, 1'b0};
        tbl[10] = '{4'b1110, 7,  4'b1110, 1'b1};
        tbl[11] = '{4'b1101, 7,  4'b1111, 1'b0};
        tbl[12] = '{4'b1101, 10, 4'b1111, 1'b0};
        tbl[13] = '{4'b1111, 7,  4'b1111, 1'b0};

        cyc(2);
        check("reset button", button, 4'hF);
        check("reset press", {3'b000, press}, 4'h0);
        reset  = 1'b0;
        chk_en = 1'b1;
        cyc(5);

        for (int i = 0; i < 14; i++) begin
            btn_raw = tbl[i].raw;
            cyc(tbl[i].cycles);
            check($sformatf("vec%0d button", i), button, tbl[i].exp_button);
            check($sformatf("vec%0d press", i), {3'b000, press}, {3'b000, tbl[i].exp_press});
        end

        // Bounce shorter than the debounce window never reaches the output.
        for (int i = 0; i < 10; i++) begin
            btn_raw = (i % 2 == 0) ? 4'b1110 : 4'b1111;
            for (int j = 0; j < 2; j++) begin
                cyc(1);
                check("bounce button", button, 4'hF);
                check("bounce press", {3'b000, press}, 4'h0);
            end
        end
        btn_raw = 4'hF;
        cyc(8);
        check("bounce settle", button, 4'hF);

        // Reset while a press is accepted and held.
        btn_raw = 4'b1110;
        cyc(7);
        check("held press", button, 4'b1110);
        reset = 1'b1;
        cyc(1);
        check("reset held button", button, 4'hF);
        check("reset held press", {3'b000, press}, 4'h0);
        reset = 1'b0;
        cyc(6);
        check("redebounce early", button, 4'hF);
        cyc(1);
        check("redebounce button", button, 4'b1110);
        check("redebounce press", {3'b000, press}, 4'h1);
        btn_raw = 4'hF;
        cyc(8);

        // Reset in the middle of a debounce count discards the partial count.
        btn_raw = 4'b1110;
        cyc(4);
        reset = 1'b1;
        cyc(1);
        check("midbounce reset", button, 4'hF);
        reset = 1'b0;
        cyc(6);
        check("midbounce early", button, 4'hF);
        cyc(1);
        check("midbounce button", button, 4'b1110);
        check("midbounce press", {3'b000, press}, 4'h1);
        btn_raw = 4'hF;
        cyc(8);

        // Long hold: auto-repeat gaps when built, steady pattern otherwise.
        btn_raw = 4'b1101;
        cyc(7);
        check("hold start button", button, 4'b1101);
        check("hold start press", {3'b000, press}, 4'h1);
        for (int k = 1; k <= 50; k++) begin
            cyc(1);
            exp_b = (AUTOREP && (k == 20 || k == 28 || k == 36 || k == 44)) ? 4'hF : 4'b1101;
            exp_p = AUTOREP && (k == 21 || k == 29 || k == 37 || k == 45);
            check($sformatf("hold k=%0d button", k), button, exp_b);
            check($sformatf("hold k=%0d press", k), {3'b000, press}, {3'b000, exp_p});
        end
        btn_raw = 4'hF;
        cyc(8);
        check("hold release", button, 4'hF);

        // Random patterns, hold lengths and reset pulses, checked by the model.
        for (int n = 0; n < 40; n++) begin
            r_sel = $urandom_range(0, 9);
            r_len = $urandom_range(1, 40);
            if (r_sel <= 3) begin
                btn_raw = 4'hF;
            end else if (r_sel <= 7) begin
                btn_raw = ~(4'b0001 << $urandom_range(0, 3));
            end else if (r_sel == 8) begin
                btn_raw = 4'($urandom_range(0, 15));
            end else begin
                reset = 1'b1;
                cyc(1);
                reset = 1'b0;
            end
            cyc(r_len);
        end
        btn_raw = 4'hF;
        cyc(10);
        check("final idle", button, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
